vga_pattern_gen: RTL and testbench

//   Parametrised VGA timing and pixel generator, replacing the fixed 640x480 sync/colour path in the pong top level.

---
 rtl/vga_pattern_gen.sv | 211 +++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing and pattern generator: pixel-tick prescaler, h/v raster counters, and a one-pixel
// output register for sync, RGB and coordinates. It offers four patterns, and the pattern is selected only at frame start.
module vga_pattern_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    input  logic [1:0]  mode,
    output logic        hscan,
    output logic        vscan,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        active,
    output logic        frame_start
);
    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(H_TOT);
    localparam int VW     = $clog2(V_TOT);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW     = ($clog2(H_ACTIVE) > HW) ? $clog2(H_ACTIVE) : HW;
    localparam int BW     = AW + 3;
    localparam int BX_MAX = H_ACTIVE - BOX_SIZE;
    localparam int BY_MAX = V_ACTIVE - BOX_SIZE;

    logic [DW-1:0] div_reg;
    logic [HW-1:0] h_reg;
    logic [VW-1:0] v_reg;
    logic          tick, h_last, v_last, frame_wrap;

    assign tick       = (div_reg == DW'(CLK_DIV - 1));
    assign h_last     = (h_reg == HW'(H_TOT - 1));
    assign v_last     = (v_reg == VW'(V_TOT - 1));
    assign frame_wrap = tick & h_last & v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick) begin
                if (h_last) begin
                    h_reg <= '0;
                    v_reg <= v_last ? '0 : v_reg + 1'b1;
                end else begin
                    h_reg <= h_reg + 1'b1;
                end
            end
        end
    end

    // 32-bit views keep comparisons and bit picks in range for any parameter set
    logic [31:0] hx, vx;
    assign hx = 32'(h_reg);
    assign vx = 32'(v_reg);

    logic hsync_raw, vsync_raw, active_raw;
    assign hsync_raw  = (hx >= 32'(H_ACTIVE + H_FP)) && (hx < 32'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_raw  = (vx >= 32'(V_ACTIVE + V_FP)) && (vx < 32'(V_ACTIVE + V_FP + V_SYNC));
    assign active_raw = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));

    logic [BW-1:0] bar_num;
    logic [2:0]    bar_idx;
    logic [11:0]   bar_rgb;
    assign bar_num = BW'(h_reg) << 3;
    assign bar_idx = 3'(bar_num / BW'(H_ACTIVE));

    for (genvar gi = 0; gi < 3; gi++) begin : g_bar
        assign bar_rgb[gi*4 +: 4] = {4{bar_idx[gi]}};
    end

    logic [1:0]    mode_q_reg;
    logic [HW-1:0] bx_reg, bx_next;
    logic [VW-1:0] by_reg, by_next;
    logic          dx_neg_reg, dx_neg_next, dy_neg_reg, dy_neg_next;
    logic          in_box, chk_cell;
    logic [11:0]   pix_c;

    assign chk_cell = hx[CHK_LOG2] ^ vx[CHK_LOG2];
    assign in_box   = (hx >= 32'(bx_reg)) && (hx < 32'(bx_reg) + 32'(BOX_SIZE)) &&
                      (vx >= 32'(by_reg)) && (vx < 32'(by_reg) + 32'(BOX_SIZE));

    always_comb begin
        pix_c = 12'h000;
        case (mode_q_reg)
            2'd0: pix_c = sw;
            2'd1: pix_c = bar_rgb;
            2'd2: pix_c = chk_cell ? sw : 12'h000;
            default: pix_c = in_box ? sw : 12'h000;
        endcase
        if (!active_raw)
            pix_c = 12'h000;
    end

    // A step that would leave the legal range bounces: direction flips and the box moves back one
    always_comb begin
        bx_next     = bx_reg;
        dx_neg_next = dx_neg_reg;
        if (!dx_neg_reg) begin
            if (32'(bx_reg) >= 32'(BX_MAX)) begin
                bx_next     = bx_reg - 1'b1;
                dx_neg_next = 1'b1;
            end else begin
                bx_next = bx_reg + 1'b1;
            end
        end else begin
            if (bx_reg == '0) begin
                bx_next     = bx_reg + 1'b1;
                dx_neg_next = 1'b0;
            end else begin
                bx_next = bx_reg - 1'b1;
            end
        end
    end

    always_comb begin
        by_next     = by_reg;
        dy_neg_next = dy_neg_reg;
        if (!dy_neg_reg) begin
            if (32'(by_reg) >= 32'(BY_MAX)) begin
                by_next     = by_reg - 1'b1;
                dy_neg_next = 1'b1;
            end else begin
                by_next = by_reg + 1'b1;
            end
        end else begin
            if (by_reg == '0) begin
                by_next     = by_reg + 1'b1;
                dy_neg_next = 1'b0;
            end else begin
                by_next = by_reg - 1'b1;
            end
        end
    end

    logic frame_start_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_reg <= 1'b0;
            mode_q_reg      <= 2'd0;
            bx_reg          <= '0;
            by_reg          <= '0;
            dx_neg_reg      <= 1'b0;
            dy_neg_reg      <= 1'b0;
        end else begin
            frame_start_reg <= frame_wrap;
            if (frame_wrap) begin
                mode_q_reg <= mode;
                if (mode_q_reg == 2'd3) begin
                    bx_reg     <= bx_next;
                    by_reg     <= by_next;
                    dx_neg_reg <= dx_neg_next;
                    dy_neg_reg <= dy_neg_next;
                end
            end
        end
    end

    // Output stage: one pixel behind the counters, advanced only on the pixel tick
    logic        hscan_reg, vscan_reg, active_reg;
    logic [11:0] rgb_reg;
    logic [10:0] pix_x_reg;
    logic [9:0]  pix_y_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hscan_reg  <= ~SYNC_POL;
            vscan_reg  <= ~SYNC_POL;
            active_reg <= 1'b0;
            rgb_reg    <= 12'h000;
            pix_x_reg  <= '0;
            pix_y_reg  <= '0;
        end else if (tick) begin
            hscan_reg  <= SYNC_POL ? hsync_raw : ~hsync_raw;
            vscan_reg  <= SYNC_POL ? vsync_raw : ~vsync_raw;
            active_reg <= active_raw;
            rgb_reg    <= pix_c;
            pix_x_reg  <= 11'(h_reg);
            pix_y_reg  <= 10'(v_reg);
        end
    end

    assign hscan       = hscan_reg;
    assign vscan       = vscan_reg;
    assign vgaR        = rgb_reg[11:8];
    assign vgaG        = rgb_reg[7:4];
    assign vgaB        = rgb_reg[3:0];
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign active      = active_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a default-horizontal/short-vertical instance for timing and patterns, plus a
// tiny-raster instance that runs the bouncing box for 26 frames.
module tb_vga_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [11:0] sw;
    logic [1:0]  mode;
    logic [1:0]  mode_b;

    logic        hscan_a, vscan_a, active_a, fs_a;
    logic [3:0]  r_a, g_a, b_a;
    logic [10:0] px_a;
    logic [9:0]  py_a;

    logic        hscan_b, vscan_b, active_b, fs_b;
    logic [3:0]  r_b, g_b, b_b;
    logic [10:0] px_b;
    logic [9:0]  py_b;

    assign mode_b = 2'd3;

    // A: 800 px lines at 4 clks/px, 7-line frames (3 active, vsync on lines 4..5)
    vga_pattern_gen #(
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_a (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode),
        .hscan(hscan_a), .vscan(vscan_a), .vgaR(r_a), .vgaG(g_a), .vgaB(b_a),
        .pix_x(px_a), .pix_y(py_a), .active(active_a), .frame_start(fs_a)
    );

    // B: 40x28 raster, 32x24 active, one clk per pixel, 8x8 box
    vga_pattern_gen #(
        .CLK_DIV(1), .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(24), .V_FP(1), .V_SYNC(2), .V_BP(1), .BOX_SIZE(8)
    ) dut_b (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode_b),
        .hscan(hscan_b), .vscan(vscan_b), .vgaR(r_b), .vgaG(g_b), .vgaB(b_b),
        .pix_x(px_b), .pix_y(py_b), .active(active_b), .frame_start(fs_b)
    );

    localparam int FT_A = 800 * 7;
    localparam int FT_B = 40 * 28;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_fs = 0;
    int b_first_x, b_first_y, b_cnt, b_frames = 0;
    bit b_found;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
        if (cyc != target) check("sched", cyc, target);
    endtask

    // Outputs show pixel p of A (counted from reset release) after clock 4*(p+1)
    task automatic pix_a(input string tag, input int f, input int x, input int y,
                         input logic [11:0] exp_rgb, input logic exp_act);
        wait_cyc(4 * (f * FT_A + y * 800 + x + 1));
        $display("pix %s f=%0d x=%0d y=%0d rgb=%03h act=%0b", tag, f, x, y, {r_a, g_a, b_a}, active_a);
        check({tag, "_rgb"}, {r_a, g_a, b_a}, exp_rgb);
        check({tag, "_act"}, active_a, exp_act);
    endtask

    always @(negedge clk) begin
        if (!rst && fs_a && first_fs == 0) first_fs = cyc;
    end

    // Box monitor for B: first lit pixel in raster order is the box corner
    always @(negedge clk) begin : box_mon
        int p, f, pos, k, ex, ey;
        if (!rst && cyc >= 1) begin
            p   = cyc - 1;
            f   = p / FT_B;
            pos = p % FT_B;
            if (pos == 0) begin
                b_found = 1'b0;
                b_cnt   = 0;
            end
            if ({r_b, g_b, b_b} != 12'h000) begin
                b_cnt++;
                if (!b_found) begin
                    b_found   = 1'b1;
                    b_first_x = pos % 40;
                    b_first_y = pos / 40;
                end
            end
            if (pos == FT_B - 1 && f >= 1 && f <= 26) begin
                k  = f - 1;
                ex = k % 48;
                if (ex > 24) ex = 48 - ex;
                ey = k % 32;
                if (ey > 16) ey = 32 - ey;
                $display("box frame %0d at (%0d,%0d) lit=%0d", f, b_first_x, b_first_y, b_cnt);
                check($sformatf("box_x_f%0d", f), b_first_x, ex);
                check($sformatf("box_y_f%0d", f), b_first_y, ey);
                check($sformatf("box_area_f%0d", f), b_cnt, 64);
                b_frames++;
            end
        end
    end

    initial begin
        int n, m;
        rst  = 1'b1;
        sw   = 12'hFFF;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset mid-line with the counters at h=300
        wait_cyc(1200);
        check("pre_rst_px", px_a, 299);
        check("pre_rst_rgb", {r_a, g_a, b_a}, 12'hFFF);
        rst = 1'b1;
        #1;
        $display("async reset: hs=%0b vs=%0b rgb=%03h act=%0b px=%0d", hscan_a, vscan_a, {r_a, g_a, b_a}, active_a, px_a);
        check("rst_hscan", hscan_a, 1'b1);
        check("rst_vscan", vscan_a, 1'b1);
        check("rst_rgb", {r_a, g_a, b_a}, 12'h000);
        check("rst_active", active_a, 1'b0);
        check("rst_fs", fs_a, 1'b0);
        check("rst_px", px_a, 0);
        check("rst_py", py_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wait_cyc(2);
        check("post_rst_act", active_a, 1'b0);
        check("post_rst_rgb", {r_a, g_a, b_a}, 12'h000);

        // Frame 0: solid white
        pix_a("solid_00", 0, 0, 0, 12'hFFF, 1'b1);
        check("px_0", px_a, 0);
        check("py_0", py_a, 0);
        pix_a("solid_639", 0, 639, 0, 12'hFFF, 1'b1);
        check("px_639", px_a, 639);
        pix_a("hblank_640", 0, 640, 0, 12'h000, 1'b0);
        pix_a("pre_hs", 0, 655, 0, 12'h000, 1'b0);
        check("hs_before", hscan_a, 1'b1);
        pix_a("hs_start", 0, 656, 0, 12'h000, 1'b0);
        check("hs_low", hscan_a, 1'b0);
        n = 0;
        while (hscan_a == 1'b0 && n < 10000) begin @(negedge clk); n++; end
        m = 0;
        while (hscan_a == 1'b1 && m < 10000) begin @(negedge clk); m++; end
        $display("hsync low=%0d clks period=%0d clks", n, n + m);
        check("hs_width", n, 384);
        check("hs_period", n + m, 3200);

        pix_a("solid_l2", 0, 10, 2, 12'hFFF, 1'b1);
        check("py_2", py_a, 2);
        mode = 2'd2;
        pix_a("no_tear", 0, 600, 2, 12'hFFF, 1'b1);
        pix_a("vblank", 0, 5, 3, 12'h000, 1'b0);
        pix_a("pre_vs", 0, 799, 3, 12'h000, 1'b0);
        check("vs_before", vscan_a, 1'b1);
        pix_a("vs_start", 0, 0, 4, 12'h000, 1'b0);
        check("vs_low", vscan_a, 1'b0);
        n = 0;
        while (vscan_a == 1'b0 && n < 20000) begin @(negedge clk); n++; end
        $display("vsync low=%0d clks", n);
        check("vs_width", n, 6400);

        wait_cyc(22399);
        check("fs_before", fs_a, 1'b0);
        wait_cyc(22400);
        check("fs_pulse", fs_a, 1'b1);
        wait_cyc(22401);
        check("fs_after", fs_a, 1'b0);
        check("fs_first", first_fs, 22400);
        sw = 12'h3C9;

        // Frame 1: checkerboard with 32-pixel squares
        pix_a("chk_0", 1, 0, 0, 12'h000, 1'b1);
        pix_a("chk_32", 1, 32, 0, 12'h3C9, 1'b1);
        check("px_32", px_a, 32);
        pix_a("chk_64", 1, 64, 0, 12'h000, 1'b1);
        pix_a("chk_96", 1, 96, 1, 12'h3C9, 1'b1);
        check("py_1", py_a, 1);
        mode = 2'd1;

        // Frame 2: colour bars, 80 pixels each
        pix_a("bar_0", 2, 0, 0, 12'h000, 1'b1);
        pix_a("bar_79", 2, 79, 0, 12'h000, 1'b1);
        pix_a("bar_80", 2, 80, 0, 12'h00F, 1'b1);
        pix_a("bar_200", 2, 200, 0, 12'h0F0, 1'b1);
        pix_a("bar_479", 2, 479, 1, 12'hF0F, 1'b1);
        pix_a("bar_639", 2, 639, 2, 12'hFFF, 1'b1);
        pix_a("bar_hblank", 2, 700, 2, 12'h000, 1'b0);
        pix_a("bar_vblank", 2, 80, 3, 12'h000, 1'b0);

        check("box_frames", b_frames, 26);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
